// File: rtl/snake_dir_ctrl.sv
// Snake game direction controller.
// Runs the IDLE/RUN/PAUSE/OVER game FSM and buffers key presses in a small
// direction queue. Each move_tick takes one queued heading and issues a step pulse.
module snake_dir_ctrl #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_center,
  input  logic       move_tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       step,
  output logic [1:0] state,
  output logic       restart,
  output logic [2:0] q_level
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(QDEPTH - 1);
  localparam logic [2:0] DEPTH_L  = 3'(QDEPTH);
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  state_t     cur_state;
  // Storage covers the largest legal depth, so the pointers never need resizing.
  // Only the first QDEPTH entries are ever written.
  logic [1:0] fifo [4];
  logic [1:0] head;
  logic [1:0] tail;

  logic       cand_vld;
  logic [1:0] cand;
  logic [1:0] tail_prev;
  logic [1:0] ref_dir;
  logic       do_tick;
  logic       do_pop;
  logic       do_push;

  assign state = cur_state;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Pick one key press, compare it with the most recent heading and decide whether to push or pop this cycle
  always_comb begin
    cand_vld = 1'b1;
    cand     = 2'b00;
    if (b_up)          cand = 2'b00;
    else if (b_down)   cand = 2'b01;
    else if (b_left)   cand = 2'b10;
    else if (b_right)  cand = 2'b11;
    else               cand_vld = 1'b0;

    tail_prev = (tail == 2'd0) ? LAST_IDX : tail - 2'd1;
    // The newest queued heading is the reference, which is the value before any pop this cycle.
    ref_dir   = (q_level != 3'd0) ? fifo[tail_prev] : dir;

    do_tick = (cur_state == RUN) && move_tick;
    do_pop  = do_tick && (q_level != 3'd0);
    // A candidate on the same axis as the reference is either a repeat or a reversal.
    // Bit 1 of the heading encodes the axis.
    do_push = (cur_state == RUN) && cand_vld && (cand[1] != ref_dir[1]) &&
              ((q_level < DEPTH_L) || do_pop);
  end

  // Game FSM, queue bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      dir       <= DIR_RIGHT;
      step      <= 1'b0;
      restart   <= 1'b0;
      q_level   <= 3'd0;
      head      <= 2'd0;
      tail      <= 2'd0;
      for (int i = 0; i < 4; i++) fifo[i] <= 2'b00;
    end else begin
      step    <= do_tick;
      restart <= 1'b0;

      if (do_pop) begin
        dir  <= fifo[head];
        head <= next_ptr(head);
      end
      if (do_push) begin
        fifo[tail] <= cand;
        tail       <= next_ptr(tail);
      end
      unique case ({do_push, do_pop})
        2'b10:   q_level <= q_level + 3'd1;
        2'b01:   q_level <= q_level - 3'd1;
        default: ;
      endcase

      // The flushes below come after the queue updates above, so they take precedence.
      unique case (cur_state)
        IDLE: begin
          if (b_center) cur_state <= RUN;
        end
        RUN: begin
          if (game_over) begin
            cur_state <= OVER;
            head      <= 2'd0;
            tail      <= 2'd0;
            q_level   <= 3'd0;
          end else if (b_center) begin
            cur_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (game_over) begin
            cur_state <= OVER;
            head      <= 2'd0;
            tail      <= 2'd0;
            q_level   <= 3'd0;
          end else if (b_center) begin
            cur_state <= RUN;
          end
        end
        OVER: begin
          if (b_center) begin
            cur_state <= IDLE;
            restart   <= 1'b1;
            dir       <= DIR_RIGHT;
            head      <= 2'd0;
            tail      <= 2'd0;
            q_level   <= 3'd0;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter: QDEPTH, default 2, depth of the pending-direction queue; legal range 1..4.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
REQ-004 b_up, b_down, b_left, b_right, b_center  input  1 each  debounced single-cycle key-press pulses.
REQ-005 move_tick  input  1  single-cycle pulse from the game step timer.
REQ-006 game_over  input  1  level, high while the game engine reports a collision.
REQ-007 dir  output  2  current heading: 00 up, 01 down, 10 left, 11 right.
REQ-008 step  output  1  single-cycle pulse; the snake advances one cell using dir.
REQ-009 state  output  2  controller state: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
REQ-010 restart  output  1  single-cycle pulse; the game engine reinitialises the board.
REQ-011 q_level  output  3  number of queued directions, 0..QDEPTH.

Function
REQ-012 The FSM shall have exactly 4 states: IDLE, RUN, PAUSE and OVER.
REQ-013 IDLE + b_center shall go to RUN.
REQ-014 RUN + b_center shall go to PAUSE.
REQ-015 PAUSE + b_center shall go to RUN.
REQ-016 OVER + b_center shall go to IDLE.
REQ-017 RUN or PAUSE with game_over high shall go to OVER; game_over shall take priority over b_center in the same cycle; game_over shall be ignored in IDLE and OVER.
REQ-018 OVER->IDLE shall assert restart for exactly one cycle (the cycle after the transition edge), flush the queue and set dir to 11.
REQ-019 Entry to OVER shall flush the queue and leave dir unchanged.
REQ-020 Direction pulses shall be accepted only in RUN; in all other states they shall be discarded with no side effect.
REQ-021 If several direction pulses coincide, exactly one is taken, priority up > down > left > right.
REQ-022 Candidate reference: the tail entry if the queue is non-empty, otherwise dir.
REQ-023 A candidate equal to the reference shall be dropped.
REQ-024 A candidate opposite to the reference shall be dropped (up/down, left/right).
REQ-025 A candidate arriving with the queue full shall be dropped; the queue contents shall be unchanged.
REQ-026 An accepted candidate shall be written to the tail; q_level shall increment on the next edge.
REQ-027 move_tick in RUN shall assert step exactly one cycle later; when the queue is non-empty, dir shall take the head entry on the same edge and the head shall pop.
REQ-028 move_tick with the queue empty shall still assert step and leave dir unchanged.
REQ-029 move_tick outside RUN shall be ignored; no step shall be issued.
REQ-030 Push and pop in the same cycle shall both occur and leave q_level unchanged.
REQ-031 On a simultaneous push and pop, the push reference shall be evaluated before the pop.
REQ-032 On a simultaneous push and pop with the queue full, the push shall succeed.
REQ-033 Queue pointers shall wrap modulo QDEPTH.
REQ-034 q_level shall never exceed QDEPTH or go below 0.
REQ-035 A move_tick in the same cycle as a RUN->PAUSE or RUN->OVER transition shall still be honoured (step issued, head popped); a move_tick in the same cycle as a PAUSE->RUN transition shall be ignored.

Reset
REQ-036 While rst_n is low, and immediately after it falls, all outputs shall take their reset values: state=IDLE, dir=11, step=0, restart=0, q_level=0, queue empty.
REQ-037 An assertion of rst_n mid-operation shall abandon any pending push, pop or step with no output glitch after release.

Verification
REQ-038 Reset release, b_center, then b_up, then move_tick -> state=01; q_level=1 after the push; one cycle after the tick dir=00, step=1, q_level=0.
REQ-039 RUN with dir=11, b_left pulse -> dropped (opposite), q_level stays 0; b_right pulse -> dropped (same direction), q_level stays 0.
REQ-040 QDEPTH=2, dir=11: b_up, b_left, b_down on separate cycles -> q_level=2 (b_down dropped); two move_ticks -> dir=00 then dir=10.
REQ-041 Queue full [00,10], b_down coincident with move_tick -> dir=00, queue=[10,01], q_level=2.
REQ-042 RUN: game_over and b_center high in the same cycle -> state=11; q_level=0; later b_center -> state=00, restart one-cycle pulse, dir=11.
REQ-043 PAUSE: move_tick and b_up -> no step, q_level unchanged; rst_n low mid-RUN with q_level=2 -> all outputs at reset values.
